tri_bus_receiver: RTL and testbench

Receiving end of the team's shared single-wire tri-state link. It samples a bus line that a remote `tri_state_buffer` drives (idle high via pull-up), deserializes one start-bit-framed word, and after a turnaround period drives an active-low acknowledge pulse onto the same wire through its own output-enable. The wire itself is resolved at top level: `bus_out` and `bus_oe` feed a local `tri_state_buffer` instance, and the resolved wire returns on `bus_in`.

---
 rtl/tri_bus_receiver.sv | 144 ++++++++++++++
 tb/tb_tri_bus_receiver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tri_bus_receiver.sv
// Receiver for the shared single-wire tri-state link.
// Deserializes one start-framed word, then drives an active-low ACK.
module tri_bus_receiver #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_in,
    output logic              bus_out,
    output logic              bus_oe,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        TURN,
        ACK
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              sync1;
    logic              s;
    logic              s_d;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W:0]   sh_next;
    logic              cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign sh_next  = {s, shreg};

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
            s_d   <= 1'b1;
        end else begin
            sync1 <= bus_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; only a true 1->0 edge leaves IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (s_d && !s) next_state = START;
            end
            START: begin
                if (cnt_zero) next_state = s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_zero && idx == LAST) next_state = STOP;
            end
            STOP: begin
                if (cnt_zero) next_state = s ? TURN : IDLE;
            end
            TURN: begin
                if (cnt_zero) next_state = ACK;
            end
            ACK: begin
                if (cnt_zero) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timing, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            bus_oe     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            bus_oe     <= (next_state == ACK);
            if (state != next_state) begin
                unique case (next_state)
                    START:   cnt <= HALF;
                    IDLE:    cnt <= '0;
                    default: cnt <= FULL;
                endcase
            end else if (state == DATA && cnt_zero) begin
                cnt <= FULL;
            end else if (!cnt_zero) begin
                cnt <= cnt - 1'b1;
            end
            if (state == START) begin
                idx <= '0;
            end
            if (state == DATA && cnt_zero) begin
                shreg <= sh_next[DATA_W:1];
                idx   <= idx + 1'b1;
            end
            if (state == STOP && cnt_zero) begin
                if (s) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

    // Combinational outputs.
    always_comb begin
        busy    = (state != IDLE);
        bus_out = 1'b0;
    end

endmodule

// File: tb/tb_tri_bus_receiver.sv
// Bench for tri_bus_receiver: two parameter sets, wired-AND bus model,
// expectations from the frame timing formulas.
module tb_tri_bus_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rem0, rem1;
    logic       line0, line1;
    logic       out0, oe0, dv0, fe0, busy0;
    logic       out1, oe1, dv1, fe1, busy1;
    logic [7:0] do0;
    logic [4:0] do1;

    int          sel;
    logic        o_out, o_oe, o_dv, o_fe, o_busy;
    logic [15:0] o_do;

    int          checks;
    int          failures;
    logic [15:0] exp_data [2];

    assign line0 = rem0 & ~(oe0 & ~out0);
    assign line1 = rem1 & ~(oe1 & ~out1);

    tri_bus_receiver #(.DATA_W(8), .BIT_CYCLES(4)) u_rx0 (
        .clk(clk), .rst_n(rst_n), .bus_in(line0),
        .bus_out(out0), .bus_oe(oe0), .data_out(do0),
        .data_valid(dv0), .frame_err(fe0), .busy(busy0)
    );

    tri_bus_receiver #(.DATA_W(5), .BIT_CYCLES(2)) u_rx1 (
        .clk(clk), .rst_n(rst_n), .bus_in(line1),
        .bus_out(out1), .bus_oe(oe1), .data_out(do1),
        .data_valid(dv1), .frame_err(fe1), .busy(busy1)
    );

    always_comb begin
        if (sel == 0) begin
            o_out = out0; o_oe = oe0; o_dv = dv0;
            o_fe = fe0; o_busy = busy0; o_do = {8'h00, do0};
        end else begin
            o_out = out1; o_oe = oe1; o_dv = dv1;
            o_fe = fe1; o_busy = busy1; o_do = {11'h000, do1};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic pat(input int n, input int w, input int b,
                                 input logic [15:0] word, input int kind);
        if (kind == 2) return (n == 0) ? 1'b0 : 1'b1;
        if (n < 0) return 1'b1;
        if (n < b) return 1'b0;
        if (n < (w + 1) * b) return word[n / b - 1];
        if (n < (w + 2) * b) return (kind != 1);
        return 1'b1;
    endfunction

    task automatic set_rem(input logic v);
        if (sel == 0) rem0 = v;
        else rem1 = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".oe"}, o_oe, 0);
        chk({tag, ".out"}, o_out, 0);
        chk({tag, ".dv"}, o_dv, 0);
        chk({tag, ".fe"}, o_fe, 0);
        chk({tag, ".busy"}, o_busy, 0);
        chk({tag, ".data"}, o_do, 0);
    endtask

    // kind: 0 good frame, 1 stop bit low, 2 one-cycle glitch
    task automatic run_frame(input int inst, input logic [15:0] word,
                             input int kind, input int abort_at);
        int   w, b, s_cyc, last;
        bit   aborted;
        logic e_dv, e_fe, e_oe, e_busy;
        logic [15:0] mask;
        sel = inst;
        w = (inst == 0) ? 8 : 5;
        b = (inst == 0) ? 4 : 2;
        mask = 16'((1 << w) - 1);
        s_cyc = b / 2 + (w + 1) * b;
        last = s_cyc + 2 * b + 1;
        aborted = 0;
        for (int n = -2; n <= last; n++) begin
            @(negedge clk);
            if (aborted) begin
                chk_reset($sformatf("abort@%0d", n));
                rst_n = 1'b1;
                break;
            end
            e_dv = (kind == 0) && (n == s_cyc + 1);
            e_fe = (kind == 1) && (n == s_cyc + 1);
            e_oe = (kind == 0) && (n >= s_cyc + b + 1) && (n <= s_cyc + 2 * b);
            if (kind == 0) e_busy = (n >= 1) && (n <= s_cyc + 2 * b);
            else if (kind == 1) e_busy = (n >= 1) && (n <= s_cyc);
            else e_busy = (n >= 1) && (n <= b / 2);
            chk($sformatf("i%0d.dv@%0d", inst, n), o_dv, e_dv);
            chk($sformatf("i%0d.fe@%0d", inst, n), o_fe, e_fe);
            chk($sformatf("i%0d.oe@%0d", inst, n), o_oe, e_oe);
            chk($sformatf("i%0d.busy@%0d", inst, n), o_busy, e_busy);
            if (n == abort_at) begin
                rst_n = 1'b0;
                set_rem(1'b1);
                aborted = 1;
            end else begin
                set_rem(pat(n + 2, w, b, word, kind));
            end
        end
        if (aborted) begin
            exp_data[0] = '0;
            exp_data[1] = '0;
        end else if (kind == 0) begin
            exp_data[inst] = word & mask;
        end
        chk($sformatf("i%0d.data", inst), o_do, exp_data[inst]);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sel = 0;
        rem0 = 1'b1;
        rem1 = 1'b1;
        rst_n = 1'b0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        sel = 1;
        #1;
        chk_reset("rst1");
        sel = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(0, 16'hA5, 0, -1);
        run_frame(0, 16'h00, 0, -1);
        run_frame(0, 16'hFF, 0, -1);
        run_frame(0, 16'h00, 2, -1);
        run_frame(0, 16'h3C, 1, -1);
        run_frame(0, 16'h77, 0, 21);
        run_frame(0, 16'h5A, 0, -1);
        run_frame(0, 16'hC3, 0, 44);
        run_frame(0, 16'h5A, 0, -1);
        run_frame(1, 16'h13, 0, -1);
        run_frame(1, 16'h00, 2, -1);
        run_frame(1, 16'h0A, 1, -1);

        for (int i = 0; i < 6; i++) begin
            run_frame(0, 16'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, -1);
        end
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 16'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
